inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 96 +++++++++
 tb/tb_inst_fetch_queue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: fetches from a combinational ROM and buffers up to DEPTH {pc, inst} entries.
// Latency: the first entry after reset or redirect appears on dq_valid two cycles later; after that, one entry per cycle.
// Backpressure: when dq_ready is low the queue fills, then fetch_pc and storage hold until decode pops.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        clrn,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dq_valid,
  input  logic        dq_ready,
  output logic [31:0] dq_inst,
  output logic [31:0] dq_pc,
  output logic [2:0]  count
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic          pop, push;

  // Pointer increment that wraps modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode and next-state computation; redirect wins over push/pop.
  always_comb begin
    dq_valid   = (count_q != 3'd0) & ~redirect;
    pop        = dq_valid & dq_ready;
    push       = ~redirect & ((count_q < DEPTH_C) | pop);
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & PC_MASK;
      count_d    = 3'd0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]   = fetch_pc_q;
        inst_mem_d[tail_q] = imem_inst;
        tail_d             = ptr_inc(tail_q);
        fetch_pc_d         = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // Control state with synchronous active-low reset; reset abandons queued entries.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      fetch_pc_q <= RESET_PC & PC_MASK;
      count_q    <= 3'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  assign imem_a  = fetch_pc_q;
  assign dq_inst = inst_mem_q[head_q];
  assign dq_pc   = pc_mem_q[head_q];
  assign count   = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: two instances (DEPTH=2/RESET_PC=0 and DEPTH=4/RESET_PC=FFFF_FFF8)
// share directed and random stimulus; each is compared every cycle against a queue-based model.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        clrn, redirect, dq_ready;
  logic [31:0] redirect_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ROM image: first two words from the AES program, the rest a hash of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0040_0493;
      32'h4:   return 32'h0104_F457;
      default: return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int          D   = (g == 0) ? 2 : 4;
    localparam logic [31:0] RPC = (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;

    logic [31:0] imem_a, imem_inst, dq_inst, dq_pc;
    logic        dq_valid;
    logic [2:0]  count;

    assign imem_inst = rom(imem_a);

    inst_fetch_queue #(.RESET_PC(RPC), .DEPTH(D)) u_dut (
      .clk        (clk),
      .clrn       (clrn),
      .imem_a     (imem_a),
      .imem_inst  (imem_inst),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .dq_valid   (dq_valid),
      .dq_ready   (dq_ready),
      .dq_inst    (dq_inst),
      .dq_pc      (dq_pc),
      .count      (count)
    );

    // Model: a queue of {pc, inst} entries plus the next address to fetch.
    logic [63:0] mq[$];
    logic [31:0] mpc;
    bit          live = 1'b0;

    always @(negedge clk) begin : model
      bit          exp_vld, do_pop, do_push;
      logic [63:0] head;
      exp_vld = (mq.size() != 0) && !redirect;
      if (live) begin
        check($sformatf("d%0d valid", g), {31'b0, dq_valid}, {31'b0, exp_vld});
        check($sformatf("d%0d count", g), {29'b0, count}, 32'(mq.size()));
        check($sformatf("d%0d imem_a", g), imem_a, mpc);
        if (exp_vld) begin
          head = mq[0];
          check($sformatf("d%0d dq_pc", g), dq_pc, head[63:32]);
          check($sformatf("d%0d dq_inst", g), dq_inst, head[31:0]);
        end
      end
      if (!clrn) begin
        mq.delete();
        mpc  = {RPC[31:2], 2'b00};
        live = 1'b1;
      end else if (redirect) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        do_pop  = exp_vld && dq_ready;
        do_push = (mq.size() < D) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back({mpc, rom(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    clrn = 1'b0; redirect = 1'b0; redirect_pc = '0; dq_ready = 1'b0;
    step(3);
    // Stream from reset with decode always ready.
    clrn = 1'b1; dq_ready = 1'b1;
    step(10);
    // Stall long enough to fill either depth, then drain.
    dq_ready = 1'b0;
    step(6);
    dq_ready = 1'b1;
    step(10);
    // Misaligned redirect while decode is ready.
    redirect = 1'b1; redirect_pc = 32'h0000_005E;
    step(1);
    redirect = 1'b0;
    step(6);
    // Reset in the middle of a stream.
    clrn = 1'b0;
    step(1);
    clrn = 1'b1;
    step(6);
    // Back-to-back redirects; the last one sets the stream.
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step(1);
    redirect_pc = 32'h0000_0200;
    step(1);
    redirect = 1'b0;
    step(8);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      clrn        = ($urandom_range(99) != 0);
      redirect    = ($urandom_range(9) == 0);
      redirect_pc = $urandom();
      dq_ready    = ($urandom_range(9) < 6);
      step(1);
    end
    clrn = 1'b1; redirect = 1'b0; dq_ready = 1'b1;
    step(4);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
